// File: rtl/mac_accumulator.sv
// ---------------------------------------------------------------------------
// mac_accumulator
//
// Sums a window of ACC_LEN 8-bit products into a saturating signed
// accumulator. Each product beat carries its own mode flag: signed
// (two's-complement) or unsigned. When the last beat of a window has been
// accepted, the block holds the result and waits for a downstream handshake
// before it starts a new window.
//
// Parameters
//    ACC_W    accumulator / result width in bits (8..32)
//    ACC_LEN  products summed per result window (1..255)
//
// Ports
//    clk        rising-edge clock
//    rst_n      synchronous, active-low reset
//    product    8-bit product from the multiplier result bus
//    sign       1 = product is two's-complement, 0 = unsigned (per beat)
//    in_valid   product/sign beat valid
//    in_ready   block can accept a beat (ACCUM state)
//    acc_clear  abort the current window and zero the partial sum
//    out_valid  acc_out holds a completed window result (HOLD state)
//    out_ready  downstream accepts the result
//    acc_out    current accumulator value (signed two's-complement)
//    overflow   sticky saturation flag for the current window
// ---------------------------------------------------------------------------
module mac_accumulator #(
   parameter int ACC_W   = 16,
   parameter int ACC_LEN = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       product,
   input  logic             sign,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             acc_clear,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] acc_out,
   output logic             overflow
);

   // Two guard bits are enough to hold acc + 255 without wrapping, even at
   // ACC_W = 8.
   localparam int SUM_W = ACC_W + 2;

   localparam logic [7:0]       LAST_BEAT = 8'(ACC_LEN - 1);
   localparam logic [ACC_W-1:0] ACC_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN   = {1'b1, {(ACC_W-1){1'b0}}};

   typedef enum logic {
      ACCUM,
      HOLD
   } state_t;

   state_t                   state;
   logic signed [ACC_W-1:0]  acc;
   logic        [7:0]        count;

   logic signed [8:0]        prod_ext;
   logic signed [SUM_W-1:0]  sum_wide;
   logic                     sum_ovf;
   logic        [ACC_W-1:0]  sum_sat;

   // Extend the incoming product to 9 signed bits using the beat's own mode
   // flag. Then form the exact sum at full width and clamp it. The sum is in
   // range only when all bits above the result's sign bit match that bit.
   always_comb begin
      prod_ext = sign ? $signed({product[7], product}) : $signed({1'b0, product});
      sum_wide = SUM_W'(acc) + SUM_W'(prod_ext);
      sum_ovf  = (sum_wide[SUM_W-1:ACC_W-1] != '0) &&
                 (sum_wide[SUM_W-1:ACC_W-1] != '1);
      if (!sum_ovf) begin
         sum_sat = sum_wide[ACC_W-1:0];
      end else if (sum_wide[SUM_W-1]) begin
         sum_sat = ACC_MIN;
      end else begin
         sum_sat = ACC_MAX;
      end
   end

   // Window control. In ACCUM, a clear wins over any beat presented in the
   // same cycle, so a window cannot complete on a clearing edge. HOLD ignores
   // beats and clears, and leaves only on the output handshake. The cycle
   // spent in HOLD is the bubble between back-to-back windows.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ACCUM;
         acc      <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               if (acc_clear) begin
                  acc      <= '0;
                  count    <= '0;
                  overflow <= 1'b0;
               end else if (in_valid) begin
                  acc      <= sum_sat;
                  overflow <= overflow | sum_ovf;
                  count    <= count + 8'd1;
                  if (count == LAST_BEAT) begin
                     state <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  acc      <= '0;
                  count    <= '0;
                  overflow <= 1'b0;
                  state    <= ACCUM;
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

   assign in_ready  = (state == ACCUM);
   assign out_valid = (state == HOLD);
   assign acc_out   = acc;

endmodule

// File: tb/tb_mac_accumulator.sv
// ---------------------------------------------------------------------------
// tb_mac_accumulator
//
// Drives two instances from the same inputs: one with ACC_W=16 and one with
// ACC_W=8, both with ACC_LEN=4. The 8-bit instance exercises saturation.
// The reference model keeps the accepted beats of the current window as
// plain integers. It computes the saturated sum by arithmetic and queues the
// expected result of each completed window. A monitor checks the handshake
// state and the visible accumulator every cycle, and pops the queue on each
// result handshake.
// ---------------------------------------------------------------------------
module tb_mac_accumulator;

   localparam int LEN = 4;

   typedef struct {
      int acc;
      bit ovf;
   } result_t;

   logic       clk;
   logic       rst_n;
   logic [7:0] product;
   logic       sign;
   logic       in_valid;
   logic       acc_clear;
   logic       out_ready;

   logic        in_ready16, out_valid16, overflow16;
   logic [15:0] acc_out16;
   logic        in_ready8, out_valid8, overflow8;
   logic [7:0]  acc_out8;

   int vectors    = 0;
   int miscompares = 0;

   int      mBeats[$];
   bit      mHold   = 1'b0;
   bit      started = 1'b0;
   result_t exp16[$];
   result_t exp8[$];

   mac_accumulator #(.ACC_W(16), .ACC_LEN(LEN)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .product(product), .sign(sign),
      .in_valid(in_valid), .in_ready(in_ready16), .acc_clear(acc_clear),
      .out_valid(out_valid16), .out_ready(out_ready), .acc_out(acc_out16),
      .overflow(overflow16)
   );

   mac_accumulator #(.ACC_W(8), .ACC_LEN(LEN)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .product(product), .sign(sign),
      .in_valid(in_valid), .in_ready(in_ready8), .acc_clear(acc_clear),
      .out_valid(out_valid8), .out_ready(out_ready), .acc_out(acc_out8),
      .overflow(overflow8)
   );

   // 10-unit clock period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Sums the current window beat by beat, clamping after each beat to the
   // range of a w-bit signed value. Any clamp sets the overflow flag.
   function automatic int satAcc(input int w, output bit ovf);
      int mx = (1 <<< (w - 1)) - 1;
      int mn = -(1 <<< (w - 1));
      int acc = 0;
      ovf = 1'b0;
      foreach (mBeats[i]) begin
         acc += mBeats[i];
         if (acc > mx) begin
            acc = mx;
            ovf = 1'b1;
         end else if (acc < mn) begin
            acc = mn;
            ovf = 1'b1;
         end
      end
      return acc;
   endfunction

   task automatic checkOutput(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: advances on every rising edge from the applied inputs
   // and its own window state.
   always @(posedge clk) begin
      bit      ov;
      result_t r;
      started = 1'b1;
      if (!rst_n) begin
         mHold = 1'b0;
         mBeats.delete();
         exp16.delete();
         exp8.delete();
      end else if (mHold) begin
         if (out_ready) begin
            mHold = 1'b0;
            mBeats.delete();
         end
      end else if (acc_clear) begin
         mBeats.delete();
      end else if (in_valid) begin
         mBeats.push_back(sign ? int'($signed(product)) : int'(product));
         if (mBeats.size() == LEN) begin
            r.acc = satAcc(16, ov);
            r.ovf = ov;
            exp16.push_back(r);
            r.acc = satAcc(8, ov);
            r.ovf = ov;
            exp8.push_back(r);
            mHold = 1'b1;
         end
      end
   end

   // Monitor: checks the visible state every cycle and scores each result
   // handshake against the queued expectation.
   always @(negedge clk) begin
      bit      o16, o8;
      int      a16, a8;
      result_t r;
      if (started) begin
         a16 = satAcc(16, o16);
         a8  = satAcc(8, o8);
         checkOutput("in_ready16", int'(in_ready16), int'(!mHold));
         checkOutput("out_valid16", int'(out_valid16), int'(mHold));
         checkOutput("acc_out16", int'($signed(acc_out16)), a16);
         checkOutput("overflow16", int'(overflow16), int'(o16));
         checkOutput("in_ready8", int'(in_ready8), int'(!mHold));
         checkOutput("out_valid8", int'(out_valid8), int'(mHold));
         checkOutput("acc_out8", int'($signed(acc_out8)), a8);
         checkOutput("overflow8", int'(overflow8), int'(o8));
         if (rst_n && out_ready && out_valid16) begin
            if (exp16.size() == 0) begin
               checkOutput("unexpected_result16", 1, 0);
            end else begin
               r = exp16.pop_front();
               checkOutput("result16_acc", int'($signed(acc_out16)), r.acc);
               checkOutput("result16_ovf", int'(overflow16), int'(r.ovf));
            end
         end
         if (rst_n && out_ready && out_valid8) begin
            if (exp8.size() == 0) begin
               checkOutput("unexpected_result8", 1, 0);
            end else begin
               r = exp8.pop_front();
               checkOutput("result8_acc", int'($signed(acc_out8)), r.acc);
               checkOutput("result8_ovf", int'(overflow8), int'(r.ovf));
            end
         end
      end
   end

   // Applies one cycle's worth of inputs just after a rising edge. The
   // inputs are then sampled on the next rising edge.
   task automatic applyStimulus(input bit rn, input bit v, input bit s,
                                input logic [7:0] p, input bit clr, input bit ordy);
      @(posedge clk);
      #1;
      rst_n     = rn;
      in_valid  = v;
      sign      = s;
      product   = p;
      acc_clear = clr;
      out_ready = ordy;
   endtask

   task automatic sendBeat(input logic [7:0] p, input bit s);
      applyStimulus(1'b1, 1'b1, s, p, 1'b0, 1'b0);
   endtask

   // Lets the held result sit for a few cycles with extra beats and a clear
   // presented, then releases it.
   task automatic holdAndRelease(input int waitCycles);
      for (int i = 0; i < waitCycles; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 8'hFF, (i == 1), 1'b0);
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
   endtask

   initial begin
      logic [7:0] signedBeats [4];
      signedBeats = '{8'hF9, 8'h10, 8'hC8, 8'h40};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      sign      = 1'b0;
      product   = 8'h00;
      acc_clear = 1'b0;
      out_ready = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

      // Unsigned window (900 at 16 bits, saturated 127 at 8 bits), with backpressure.
      for (int i = 0; i < LEN; i++) sendBeat(8'hE1, 1'b0);
      holdAndRelease(3);

      // Signed window: -7 + 16 - 56 + 64 = 17.
      for (int i = 0; i < LEN; i++) sendBeat(signedBeats[i], 1'b1);
      holdAndRelease(1);

      // Negative saturation at 8 bits: 4 x -128.
      for (int i = 0; i < LEN; i++) sendBeat(8'h80, 1'b1);
      holdAndRelease(2);

      // Clear mid-window with a beat in the same cycle, then a fresh window.
      sendBeat(8'h40, 1'b1);
      sendBeat(8'h40, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b1, 8'h40, 1'b1, 1'b0);
      sendBeat(8'h05, 1'b0);
      sendBeat(8'hFE, 1'b1);
      sendBeat(8'h7F, 1'b0);
      sendBeat(8'h80, 1'b0);
      holdAndRelease(1);

      // Clear on what would be the final beat of a window.
      for (int i = 0; i < LEN - 1; i++) sendBeat(8'h11, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0);

      // Reset while a result is held.
      for (int i = 0; i < LEN; i++) sendBeat(8'h33, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

      // Back-to-back windows with out_ready held high.
      for (int i = 0; i < 2 * LEN + 2; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 8'(i + 1), 1'b0, 1'b1);
      end

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         applyStimulus(($urandom_range(99) != 0),
                       ($urandom_range(99) < 70),
                       1'($urandom_range(1)),
                       8'($urandom_range(255)),
                       ($urandom_range(99) < 5),
                       ($urandom_range(99) < 60));
      end

      // Drain any held result, then check nothing is left outstanding.
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      @(negedge clk);
      #1;
      checkOutput("exp16_drained", exp16.size(), 0);
      checkOutput("exp8_drained", exp8.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
